// File: rtl/bcd_conv_arbiter.sv
// Two-requester binary-to-BCD converter: arbitrates between req0/req1 and runs a
// 10-step double-dabble conversion on the winner's operand.
module bcd_conv_arbiter #(
    parameter int FIX_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [9:0] bin0,
    input  logic       req1,
    input  logic [9:0] bin1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic       owner,
    output logic [3:0] cen,
    output logic [3:0] dez,
    output logic [3:0] und
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [9:0] shreg;
    logic [3:0] wcen;
    logic [3:0] wdez;
    logic [3:0] wund;
    logic       wowner;
    logic       last_gnt;

    logic       any_req;
    logic       winner;
    logic [3:0] adj_dez;
    logic [3:0] adj_und;
    logic [3:0] nxt_cen;
    logic [3:0] nxt_dez;
    logic [3:0] nxt_und;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            winner = (FIX_PRIORITY != 0) ? 1'b0 : ~last_gnt;
        end else begin
            winner = ~req0;
        end
    end

    // The hundreds digit is never adjusted: it is the top digit, so it simply
    // accumulates floor(bin/100) in binary, which is how 1023 yields cen=10.
    always_comb begin
        adj_dez = (wdez >= 4'd5) ? wdez + 4'd3 : wdez;
        adj_und = (wund >= 4'd5) ? wund + 4'd3 : wund;
        nxt_cen = {wcen[2:0], adj_dez[3]};
        nxt_dez = {adj_dez[2:0], adj_und[3]};
        nxt_und = {adj_und[2:0], shreg[9]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = SHIFT;
            SHIFT:   if (cnt == 4'd9) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 4'd0;
            shreg    <= 10'd0;
            wcen     <= 4'd0;
            wdez     <= 4'd0;
            wund     <= 4'd0;
            wowner   <= 1'b0;
            last_gnt <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            owner    <= 1'b0;
            cen      <= 4'd0;
            dez      <= 4'd0;
            und      <= 4'd0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        shreg    <= winner ? bin1 : bin0;
                        wcen     <= 4'd0;
                        wdez     <= 4'd0;
                        wund     <= 4'd0;
                        cnt      <= 4'd0;
                        wowner   <= winner;
                        last_gnt <= winner;
                        gnt0     <= ~winner;
                        gnt1     <= winner;
                    end
                end
                SHIFT: begin
                    wcen  <= nxt_cen;
                    wdez  <= nxt_dez;
                    wund  <= nxt_und;
                    shreg <= {shreg[8:0], 1'b0};
                    cnt   <= cnt + 4'd1;
                    // Final iteration: publish the freshly shifted digits directly.
                    if (cnt == 4'd9) begin
                        cen   <= nxt_cen;
                        dez   <= nxt_dez;
                        und   <= nxt_und;
                        owner <= wowner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: a cycle-level reference model predicts
// grants, busy, done and the decimal digits of every accepted operand.
module tb_bcd_conv_arbiter;

    typedef struct packed {
        logic       owner;
        logic [3:0] cen;
        logic [3:0] dez;
        logic [3:0] und;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [9:0] bin0 = 10'd0;
    logic [9:0] bin1 = 10'd0;

    logic       gnt0, gnt1, busy, done, owner;
    logic [3:0] cen, dez, und;
    logic       f_gnt0, f_gnt1, f_busy, f_done, f_owner;
    logic [3:0] f_cen, f_dez, f_und;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int model_done_count = 0;

    res_t exp_q[$];
    res_t held = '0;
    logic rr_owner_q[$];
    logic fix_owner_q[$];
    logic record = 1'b0;

    int   m_cnt = 0;
    logic m_last = 1'b1;
    logic m_gnt0 = 1'b0;
    logic m_gnt1 = 1'b0;
    logic m_done = 1'b0;

    bcd_conv_arbiter #(.FIX_PRIORITY(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .owner(owner),
        .cen(cen), .dez(dez), .und(und)
    );

    bcd_conv_arbiter #(.FIX_PRIORITY(1)) dut_fix (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .busy(f_busy), .done(f_done), .owner(f_owner),
        .cen(f_cen), .dez(f_dez), .und(f_und)
    );

    initial forever #5 clk = ~clk;

    function automatic res_t expect_res(input logic o, input logic [9:0] v);
        res_t r;
        int x;
        x = int'(v);
        r.owner = o;
        r.cen   = 4'(x / 100);
        r.dez   = 4'((x / 10) % 10);
        r.und   = 4'(x % 10);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: acceptance in idle, done in the cycle after the 10th shift edge.
    always @(posedge clk or negedge rst_n) begin
        logic w;
        if (!rst_n) begin
            m_cnt  = 0;
            m_last = 1'b1;
            m_gnt0 = 1'b0;
            m_gnt1 = 1'b0;
            m_done = 1'b0;
            exp_q.delete();
        end else begin
            m_gnt0 = 1'b0;
            m_gnt1 = 1'b0;
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (req0 || req1) begin
                    w = (req0 && req1) ? ~m_last : req1;
                    m_last = w;
                    m_gnt0 = ~w;
                    m_gnt1 = w;
                    exp_q.push_back(expect_res(w, w ? bin1 : bin0));
                    m_cnt = 11;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 1) begin
                    m_done = 1'b1;
                    model_done_count++;
                end
            end
        end
    end

    // Monitor: compare every cycle, pop the scoreboard on each DUT done pulse.
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            held = '0;
        end else if (done) begin
            done_count++;
            checkOutput("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("owner", 32'(owner), 32'(e.owner));
                checkOutput("cen", 32'(cen), 32'(e.cen));
                checkOutput("dez", 32'(dez), 32'(e.dez));
                checkOutput("und", 32'(und), 32'(e.und));
                held = e;
            end
            if (record) rr_owner_q.push_back(owner);
        end
        if (f_done && record) fix_owner_q.push_back(f_owner);
        checkOutput("gnt0", 32'(gnt0), 32'(m_gnt0));
        checkOutput("gnt1", 32'(gnt1), 32'(m_gnt1));
        checkOutput("busy", 32'(busy), 32'(m_cnt != 0));
        checkOutput("done", 32'(done), 32'(m_done));
        checkOutput("hold", 32'({owner, cen, dez, und}), 32'(held));
    end

    // Drives one request pattern, drops each req on its grant, returns when idle.
    task automatic applyStimulus(input logic r0, input logic r1, input logic [9:0] b0, input logic [9:0] b1);
        int budget;
        @(negedge clk);
        req0 = r0;
        req1 = r1;
        bin0 = b0;
        bin1 = b1;
        budget = 0;
        while ((req0 || req1 || busy) && budget < 100) begin
            @(negedge clk);
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            budget++;
        end
        checkOutput("stim_budget", 32'(budget < 100), 32'd1);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int budget;
        logic [3:0] rr_exp;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_digits", 32'({cen, dez, und}), 32'd0);
        #1 rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 10'd255, 10'd0);
        applyStimulus(1'b0, 1'b1, 10'd0, 10'd1023);
        applyStimulus(1'b0, 1'b1, 10'd0, 10'd0);

        doReset();
        applyStimulus(1'b1, 1'b1, 10'd7, 10'd999);

        doReset();
        rr_owner_q.delete();
        fix_owner_q.delete();
        record = 1'b1;
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b1;
        bin0 = 10'd321;
        bin1 = 10'd654;
        n = 0;
        budget = 0;
        while (n < 4 && budget < 200) begin
            @(negedge clk);
            if (done) n++;
            budget++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        budget = 0;
        while (busy && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        record = 1'b0;
        checkOutput("held_budget", 32'(budget < 50), 32'd1);
        checkOutput("rr_count", 32'(rr_owner_q.size()), 32'd4);
        checkOutput("fix_count", 32'(fix_owner_q.size()), 32'd4);
        rr_exp = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            if (i < rr_owner_q.size()) checkOutput("rr_owner_seq", 32'(rr_owner_q[i]), 32'(rr_exp[i]));
            if (i < fix_owner_q.size()) checkOutput("fix_owner_seq", 32'(fix_owner_q[i]), 32'd0);
        end

        @(negedge clk);
        req0 = 1'b1;
        bin0 = 10'd500;
        budget = 0;
        while (!gnt0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("abort_gnt_budget", 32'(budget < 20), 32'd1);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_owner", 32'(owner), 32'd0);
        checkOutput("abort_digits", 32'({cen, dez, und}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 10'd100, 10'd0);
        checkOutput("after_abort", 32'({owner, cen, dez, und}), 32'h100);

        for (int v = 0; v < 1024; v++) begin
            applyStimulus(1'b1, 1'b1, 10'(v), 10'(1023 - v));
        end

        repeat (2) @(negedge clk);
        checkOutput("done_total", 32'(done_count), 32'(model_done_count));
        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
